wdt_timeout_ctrl: RTL and testbench

- Downstream consumer of the watchdog wrapper's WTO output, in the system (AXI) clock domain.
- Synchronises WTO and counts timeout events.
- Raises a CPU interrupt. If software does not clear it within a grace window, escalates to a fixed-length system reset request.
- Sits between the watchdog wrapper and the CPU interrupt / system reset logic.

---
 rtl/wdt_timeout_ctrl.sv | 117 +++++++++++
 tb/tb_wdt_timeout_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_timeout_ctrl.sv
// Watchdog timeout controller: synchronises WTO, counts timeout events, raises IRQ
// and escalates to a fixed-length system reset request if software does not acknowledge.
module wdt_timeout_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GRACE_CYCLES = 1024,
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             WTO,
  input  logic             IRQ_EN,
  input  logic             IRQ_CLR,
  input  logic             TO_CNT_CLR,
  output logic             IRQ,
  output logic             SYS_RST_REQ,
  output logic [CNT_W-1:0] TO_CNT
);

  localparam int unsigned GW = $clog2(GRACE_CYCLES + 1);
  localparam int unsigned PW = $clog2(RST_PULSE + 1);

  typedef enum logic [1:0] {S_IDLE, S_IRQ, S_RESET, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grace_q, grace_d;
  logic [PW-1:0]          pulse_q, pulse_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   wto_s, wto_q, rise;
  logic                   irq_d, rst_req_d;

  assign wto_s = sync_q[SYNC_STAGES-1];
  assign rise  = wto_s & ~wto_q;

  // WTO synchroniser and edge-detect flop
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sync_q <= '0;
      wto_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], WTO};
      wto_q  <= wto_s;
    end
  end

  // Saturating timeout-event counter; clear wins over a simultaneous edge
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      TO_CNT <= '0;
    end else if (TO_CNT_CLR) begin
      TO_CNT <= '0;
    end else if (rise && (TO_CNT != '1)) begin
      TO_CNT <= TO_CNT + CNT_W'(1);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      grace_q     <= '0;
      pulse_q     <= '0;
      IRQ         <= 1'b0;
      SYS_RST_REQ <= 1'b0;
    end else begin
      state_q     <= state_d;
      grace_q     <= grace_d;
      pulse_q     <= pulse_d;
      IRQ         <= irq_d;
      SYS_RST_REQ <= rst_req_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d   = state_q;
    grace_d   = grace_q;
    pulse_d   = pulse_q;
    irq_d     = 1'b0;
    rst_req_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise && IRQ_EN) begin
          state_d = S_IRQ;
          grace_d = GW'(GRACE_CYCLES - 1);
        end
      end
      S_IRQ: begin
        if (IRQ_CLR || !IRQ_EN) begin
          state_d = S_IDLE;
        end else if (grace_q == '0) begin
          state_d = S_RESET;
          pulse_d = PW'(RST_PULSE - 1);
        end else begin
          grace_d = grace_q - GW'(1);
        end
      end
      S_RESET: begin
        if (pulse_q == '0) begin
          state_d = S_HOLD;
        end else begin
          pulse_d = pulse_q - PW'(1);
        end
      end
      S_HOLD: begin
        // Stay here until WTO is seen low so a stuck timeout cannot re-trigger
        if (!wto_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    irq_d     = (state_d == S_IRQ) || (state_d == S_RESET);
    rst_req_d = (state_d == S_RESET);
  end

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// Scoreboard bench for wdt_timeout_ctrl: every change of {IRQ,SYS_RST_REQ,TO_CNT}
// is matched against the next queued expectation, including the cycle it should occur on.
module tb_wdt_timeout_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESETn, WTO, IRQ_EN, IRQ_CLR, TO_CNT_CLR;
  logic       IRQ, SYS_RST_REQ;
  logic [1:0] TO_CNT;

  wdt_timeout_ctrl #(
    .SYNC_STAGES (2),
    .GRACE_CYCLES(8),
    .RST_PULSE   (4),
    .CNT_W       (2)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .WTO        (WTO),
    .IRQ_EN     (IRQ_EN),
    .IRQ_CLR    (IRQ_CLR),
    .TO_CNT_CLR (TO_CNT_CLR),
    .IRQ        (IRQ),
    .SYS_RST_REQ(SYS_RST_REQ),
    .TO_CNT     (TO_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string    tag;
    logic [3:0] outs;
    int       at;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] prev_outs = 4'b0000;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic expect_at(input string tag, input bit irq, input bit rst, input int cnt,
                           input int dt);
    exp_t e;
    e.tag  = tag;
    e.outs = {irq, rst, 2'(cnt)};
    e.at   = cyc + dt;
    sb_q.push_back(e);
  endtask

  always @(posedge ACLK) cyc++;

  // Output monitor: any change must match the head of the scoreboard
  always @(negedge ACLK) begin
    logic [3:0] cur;
    exp_t e;
    cur = {IRQ, SYS_RST_REQ, TO_CNT};
    if (cur !== prev_outs) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_change", 32'(cur), 32'(prev_outs));
      end else begin
        e = sb_q.pop_front();
        check_eq({e.tag, "_out"}, 32'(cur), 32'(e.outs));
        check_eq({e.tag, "_cyc"}, 32'(cyc), 32'(e.at));
      end
      prev_outs = cur;
    end
  end

  initial begin
    ARESETn = 1'b0; WTO = 1'b0; IRQ_EN = 1'b0; IRQ_CLR = 1'b0; TO_CNT_CLR = 1'b0;

    // Reset held with WTO toggling: outputs stay cleared
    for (int i = 0; i < 5; i++) begin
      tick(1);
      WTO = ~WTO;
      check_eq("rst_outs", 32'({IRQ, SYS_RST_REQ, TO_CNT}), 32'd0);
    end
    WTO = 1'b0;
    tick(1);
    ARESETn = 1'b1;
    tick(6);

    // Interrupt then acknowledge on the 5th IRQ cycle
    IRQ_EN = 1'b1;
    WTO    = 1'b1;
    expect_at("irq_on", 1, 0, 1, 3);
    tick(7);
    IRQ_CLR = 1'b1;
    expect_at("irq_ack", 0, 0, 1, 1);
    tick(1);
    IRQ_CLR = 1'b0;
    tick(2);
    WTO = 1'b0;
    tick(4);

    // Escalation: 8 IRQ cycles, 4 reset cycles, then HOLD while WTO stays high
    WTO = 1'b1;
    expect_at("esc_irq", 1, 0, 2, 3);
    expect_at("esc_rst", 1, 1, 2, 11);
    expect_at("esc_hold", 0, 0, 2, 15);
    tick(20);
    WTO = 1'b0;
    tick(4);
    WTO = 1'b1;
    expect_at("rearm_irq", 1, 0, 3, 3);
    tick(3);
    IRQ_CLR = 1'b1;
    expect_at("rearm_ack", 0, 0, 3, 1);
    tick(1);
    IRQ_CLR = 1'b0;
    WTO = 1'b0;
    tick(4);

    TO_CNT_CLR = 1'b1;
    expect_at("cnt_clr", 0, 0, 0, 1);
    tick(1);
    TO_CNT_CLR = 1'b0;

    // Masked pulses count only; then saturation at 3
    IRQ_EN = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      WTO = 1'b1;
      if (i <= 3) expect_at("masked_cnt", 0, 0, i, 3);
      tick(4);
      WTO = 1'b0;
      tick(4);
    end
    check_eq("sat_cnt", 32'(TO_CNT), 32'd3);

    // Clear in the same cycle as a rise wins
    WTO = 1'b1;
    tick(2);
    TO_CNT_CLR = 1'b1;
    expect_at("clr_prio", 0, 0, 0, 1);
    tick(1);
    TO_CNT_CLR = 1'b0;
    tick(3);
    check_eq("clr_prio_cnt", 32'(TO_CNT), 32'd0);
    WTO = 1'b0;
    tick(4);

    // Dropping IRQ_EN mid-IRQ masks the interrupt next cycle
    IRQ_EN = 1'b1;
    WTO    = 1'b1;
    expect_at("mask_irq", 1, 0, 1, 3);
    tick(5);
    IRQ_EN = 1'b0;
    expect_at("mask_drop", 0, 0, 1, 1);
    tick(1);
    WTO = 1'b0;
    tick(4);

    // Asynchronous reset while the reset request is active
    IRQ_EN = 1'b1;
    WTO    = 1'b1;
    expect_at("ar_irq", 1, 0, 2, 3);
    expect_at("ar_rst", 1, 1, 2, 11);
    tick(13);
    check_eq("ar_pre_req", 32'(SYS_RST_REQ), 32'd1);
    expect_at("ar_async", 0, 0, 0, 1);
    #2 ARESETn = 1'b0;
    #1;
    check_eq("ar_irq_drop", 32'(IRQ), 32'd0);
    check_eq("ar_req_drop", 32'(SYS_RST_REQ), 32'd0);
    check_eq("ar_cnt_drop", 32'(TO_CNT), 32'd0);
    WTO = 1'b0;
    tick(2);
    ARESETn = 1'b1;
    tick(4);
    WTO = 1'b1;
    expect_at("post_irq", 1, 0, 1, 3);
    tick(3);
    IRQ_CLR = 1'b1;
    expect_at("post_ack", 0, 0, 1, 1);
    tick(1);
    IRQ_CLR = 1'b0;
    WTO = 1'b0;
    tick(4);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
